// File: rtl/spi_bus_pkg.sv
// Purpose: shared types and default timing for the SPI bus arbiter.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package spi_bus_pkg;

    localparam int BYTE_W = 8;   // SPI engine byte width
    localparam int IDX_W  = 2;   // requester index width (N_REQ up to 4)
    localparam int CNT_W  = 16;  // phase counter width

    localparam logic [CNT_W-1:0] DEF_CS_SETUP = 16'h00FF;
    localparam logic [CNT_W-1:0] DEF_CS_HOLD  = 16'h00FF;
    localparam logic [CNT_W-1:0] DEF_CS_GAP   = 16'h00FF;
    localparam logic [CNT_W-1:0] DEF_TIMEOUT  = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_XFER  = 3'd2,
        ST_BUSY  = 3'd3,
        ST_NEXT  = 3'd4,
        ST_HOLD  = 3'd5,
        ST_GAP   = 3'd6
    } state_t;

    // Next index after idx, wrapping at n.
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx, input int n);
        return (int'(idx) == n - 1) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/spi_bus_arbiter_rr.sv
// Purpose: round-robin picker; first request at or after the pointer, wrapping.
// Latency: grant is combinational; pointer update takes effect the next cycle.
// Backpressure: none; caller decides when a grant is taken (i_upd).
// Ports: i_req requests, i_upd/i_upd_idx advance pointer past the finished owner,
//        o_grant one-hot pick, o_idx its index, o_any any request present.
module rr_arbiter
    import spi_bus_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N_REQ-1:0]  i_req,
    input  logic              i_upd,
    input  logic [IDX_W-1:0]  i_upd_idx,
    output logic [N_REQ-1:0]  o_grant,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_any
);

    logic [IDX_W-1:0] r_ptr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (i_upd) begin
            r_ptr <= wrap_inc(i_upd_idx, N_REQ);
        end
    end

    // Two passes: indices at/above the pointer first, then the wrapped ones.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int j = 0; j < N_REQ; j++) begin
            if (!o_any && i_req[j] && (j >= int'(r_ptr))) begin
                o_any      = 1'b1;
                o_grant[j] = 1'b1;
                o_idx      = IDX_W'(j);
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            if (!o_any && i_req[j] && (j < int'(r_ptr))) begin
                o_any      = 1'b1;
                o_grant[j] = 1'b1;
                o_idx      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Purpose: shares one byte SPI engine among N_REQ requesters with per-requester cs_n timing.
// Latency: cs_n fall to first tx_begin = CS_SETUP+2 clk; byte-to-byte = SPI time + 3 clk.
// Backpressure: requester holds req/tx_byte/last until its ack; others wait until the bus frees.
// Ports: i_req/i_last/i_tx_byte per requester in; o_grant/o_ack/o_rx_byte/o_timeout_err out;
//        o_cs_n chip selects; o_spi_tx_begin/o_spi_tx_data to the engine, i_spi_tx_end/i_spi_rx_data back.
module spi_bus_arbiter
    import spi_bus_pkg::*;
#(
    parameter int               N_REQ    = 2,
    parameter logic [CNT_W-1:0] CS_SETUP = DEF_CS_SETUP,
    parameter logic [CNT_W-1:0] CS_HOLD  = DEF_CS_HOLD,
    parameter logic [CNT_W-1:0] CS_GAP   = DEF_CS_GAP,
    parameter logic [CNT_W-1:0] TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [N_REQ-1:0]        i_req,
    input  logic [N_REQ-1:0]        i_last,
    input  logic [BYTE_W*N_REQ-1:0] i_tx_byte,
    output logic [N_REQ-1:0]        o_grant,
    output logic [N_REQ-1:0]        o_ack,
    output logic [BYTE_W-1:0]       o_rx_byte,
    output logic                    o_timeout_err,
    output logic [N_REQ-1:0]        o_cs_n,
    output logic                    o_spi_tx_begin,
    output logic [BYTE_W-1:0]       o_spi_tx_data,
    input  logic                    i_spi_tx_end,
    input  logic [BYTE_W-1:0]       i_spi_rx_data
);

    state_t             r_state, w_state;
    logic [CNT_W-1:0]   r_cnt, w_cnt;
    logic [IDX_W-1:0]   r_gidx, w_gidx;
    logic               r_last, w_last;
    logic [N_REQ-1:0]   r_grant, w_grant;
    logic [N_REQ-1:0]   r_ack, w_ack;
    logic [BYTE_W-1:0]  r_rx_byte, w_rx_byte;
    logic               r_timeout_err, w_timeout_err;
    logic [N_REQ-1:0]   r_cs_n, w_cs_n;
    logic               r_tx_begin, w_tx_begin;
    logic [BYTE_W-1:0]  r_tx_data, w_tx_data;

    logic               w_upd;
    logic [N_REQ-1:0]   w_arb_grant;
    logic [IDX_W-1:0]   w_arb_idx;
    logic               w_arb_any;
    logic [BYTE_W-1:0]  w_sel_byte;
    logic               w_sel_last;
    logic               w_sel_req;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_req     (i_req),
        .i_upd     (w_upd),
        .i_upd_idx (r_gidx),
        .o_grant   (w_arb_grant),
        .o_idx     (w_arb_idx),
        .o_any     (w_arb_any)
    );

    // Inputs of the current owner.
    always_comb begin
        w_sel_byte = '0;
        w_sel_last = 1'b0;
        w_sel_req  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (r_gidx == IDX_W'(k)) begin
                w_sel_byte = i_tx_byte[BYTE_W*k +: BYTE_W];
                w_sel_last = i_last[k];
                w_sel_req  = i_req[k];
            end
        end
    end

    always_comb begin
        w_state       = r_state;
        w_cnt         = r_cnt + 1'b1;
        w_gidx        = r_gidx;
        w_last        = r_last;
        w_grant       = r_grant;
        w_ack         = '0;
        w_rx_byte     = r_rx_byte;
        w_timeout_err = 1'b0;
        w_cs_n        = r_cs_n;
        w_tx_begin    = 1'b0;
        w_tx_data     = r_tx_data;
        w_upd         = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_arb_any) begin
                    w_grant = w_arb_grant;
                    w_cs_n  = ~w_arb_grant;
                    w_gidx  = w_arb_idx;
                    w_state = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (r_cnt == CS_SETUP) w_state = ST_XFER;
            end
            ST_XFER: begin
                w_tx_begin = 1'b1;
                w_tx_data  = w_sel_byte;
                w_last     = w_sel_last;
                w_state    = ST_BUSY;
            end
            ST_BUSY: begin
                // End pulses are only honoured here; elsewhere they are stale or spurious.
                if (i_spi_tx_end) begin
                    w_rx_byte = i_spi_rx_data;
                    w_ack     = r_grant;
                    w_state   = r_last ? ST_HOLD : ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (w_sel_req) begin
                    w_state = ST_XFER;
                end else if (r_cnt == TIMEOUT) begin
                    w_timeout_err = 1'b1;
                    w_state       = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (r_cnt == CS_HOLD) begin
                    w_cs_n  = '1;
                    w_grant = '0;
                    w_upd   = 1'b1;
                    w_state = ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_cnt == CS_GAP) w_state = ST_IDLE;
            end
            default: w_state = ST_IDLE;
        endcase
        // Every phase measures from its own entry.
        if (w_state != r_state) w_cnt = '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_gidx        <= '0;
            r_last        <= 1'b0;
            r_grant       <= '0;
            r_ack         <= '0;
            r_rx_byte     <= '0;
            r_timeout_err <= 1'b0;
            r_cs_n        <= '1;
            r_tx_begin    <= 1'b0;
            r_tx_data     <= '0;
        end else begin
            r_state       <= w_state;
            r_cnt         <= w_cnt;
            r_gidx        <= w_gidx;
            r_last        <= w_last;
            r_grant       <= w_grant;
            r_ack         <= w_ack;
            r_rx_byte     <= w_rx_byte;
            r_timeout_err <= w_timeout_err;
            r_cs_n        <= w_cs_n;
            r_tx_begin    <= w_tx_begin;
            r_tx_data     <= w_tx_data;
        end
    end

    assign o_grant        = r_grant;
    assign o_ack          = r_ack;
    assign o_rx_byte      = r_rx_byte;
    assign o_timeout_err  = r_timeout_err;
    assign o_cs_n         = r_cs_n;
    assign o_spi_tx_begin = r_tx_begin;
    assign o_spi_tx_data  = r_tx_data;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Purpose: directed scoreboard bench for spi_bus_arbiter with a byte-echo SPI engine model.
// Latency: n/a.
// Backpressure: requester model holds each byte until its ack.
module tb_spi_bus_arbiter;

    localparam int SETUP = 4;
    localparam int HOLD  = 3;
    localparam int GAP   = 5;
    localparam int TMO   = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = '0;
    logic [1:0]  last = '0;
    logic [15:0] tx_byte = '0;
    logic        spi_end = 1'b0;
    logic [7:0]  spi_rx = '0;

    logic [1:0]  o_grant, o_ack, o_cs_n;
    logic [7:0]  o_rx_byte, o_spi_tx_data;
    logic        o_timeout_err, o_spi_tx_begin;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ack_cnt = 0;
    int terr_cnt = 0;
    int overlap = 0;
    int hi_run = 0;
    bit seen_low = 1'b0;
    logic [1:0] prev_grant = '0;
    logic [7:0] mon_e;

    logic [8:0]  tx_q[2][$];   // {last, byte} per requester
    logic [7:0]  exp_q[2][$];  // expected rx per requester
    logic [1:0]  grant_log[$];
    int          gap_log[$];

    int          spi_lat = 3;
    int          spi_cnt = 0;
    logic [7:0]  spi_dat = '0;
    logic        inj_end = 1'b0;

    spi_bus_arbiter #(
        .N_REQ(2), .CS_SETUP(16'(SETUP)), .CS_HOLD(16'(HOLD)),
        .CS_GAP(16'(GAP)), .TIMEOUT(16'(TMO))
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_last(last), .i_tx_byte(tx_byte),
        .o_grant(o_grant), .o_ack(o_ack), .o_rx_byte(o_rx_byte),
        .o_timeout_err(o_timeout_err), .o_cs_n(o_cs_n),
        .o_spi_tx_begin(o_spi_tx_begin), .o_spi_tx_data(o_spi_tx_data),
        .i_spi_tx_end(spi_end), .i_spi_rx_data(spi_rx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor, requester model and SPI engine model, all on the falling edge.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (o_ack != 2'b00) begin
                ack_cnt++;
                for (int i = 0; i < 2; i++) begin
                    if (o_ack[i]) begin
                        if (exp_q[i].size() == 0) begin
                            check("ack_unexpected", 32'(o_ack), 32'd0);
                        end else begin
                            mon_e = exp_q[i].pop_front();
                            check(i == 0 ? "ack0_rx" : "ack1_rx", 32'(o_rx_byte), 32'(mon_e));
                        end
                    end
                end
            end
            if (o_timeout_err) terr_cnt++;
        end
        if (!o_cs_n[0] && !o_cs_n[1]) overlap++;
        if (o_grant != 2'b00 && prev_grant == 2'b00) grant_log.push_back(o_grant);
        prev_grant = o_grant;
        if (&o_cs_n) begin
            hi_run++;
        end else begin
            if (hi_run > 0 && seen_low) gap_log.push_back(hi_run);
            hi_run = 0;
            seen_low = 1'b1;
        end
        // Requesters: retire the head on ack, present the next byte at once.
        for (int i = 0; i < 2; i++) begin
            if (o_ack[i] && tx_q[i].size() > 0) void'(tx_q[i].pop_front());
            if (tx_q[i].size() > 0) begin
                req[i] = 1'b1;
                last[i] = tx_q[i][0][8];
                tx_byte[8*i +: 8] = tx_q[i][0][7:0];
            end else begin
                req[i] = 1'b0;
                last[i] = 1'b0;
            end
        end
        // SPI engine: echoes the inverted byte spi_lat cycles after tx_begin.
        spi_end = 1'b0;
        if (spi_cnt > 0) begin
            spi_cnt--;
            if (spi_cnt == 0) begin
                spi_end = 1'b1;
                spi_rx = ~spi_dat;
            end
        end else if (o_spi_tx_begin) begin
            spi_dat = o_spi_tx_data;
            spi_cnt = spi_lat;
        end
        if (inj_end) begin
            spi_end = 1'b1;
            spi_rx = 8'hA5;
        end
    end

    task automatic push(input int i, input logic [7:0] b, input logic l);
        tx_q[i].push_back({l, b});
        exp_q[i].push_back(~b);
    endtask

    task automatic wait_sig(input string tag, input int which, output int at);
        bit hit = 1'b0;
        at = cyc;
        for (int k = 0; k < 2000 && !hit; k++) begin
            @(negedge clk);
            case (which)
                0: hit = !o_cs_n[0];
                1: hit = !o_cs_n[1];
                2: hit = o_spi_tx_begin;
                3: hit = o_timeout_err;
                4: hit = o_cs_n[0];
                5: hit = o_ack[0];
                default: hit = 1'b1;
            endcase
            at = cyc;
        end
        check(tag, 32'(hit), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 1'b0;
        for (int k = 0; k < 3000 && !ok; k++) begin
            @(negedge clk);
            ok = (tx_q[0].size() == 0 && tx_q[1].size() == 0 &&
                  o_grant == 2'b00 && o_cs_n == 2'b11);
        end
        check(tag, 32'(ok), 32'd1);
        repeat (GAP + 4) @(negedge clk);
    endtask

    initial begin
        int t_a, t_b, a0, o0, tr0, gmin;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_grant", 32'(o_grant), 32'd0);
        check("rst_ack", 32'(o_ack), 32'd0);
        check("rst_rx", 32'(o_rx_byte), 32'd0);
        check("rst_terr", 32'(o_timeout_err), 32'd0);
        check("rst_cs_n", 32'(o_cs_n), 32'h3);
        check("rst_begin", 32'(o_spi_tx_begin), 32'd0);
        check("rst_data", 32'(o_spi_tx_data), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single requester, three-byte transaction
        a0 = ack_cnt;
        push(0, 8'hE8, 1'b0);
        push(0, 8'h00, 1'b0);
        push(0, 8'h00, 1'b1);
        wait_sig("t1_cs0_low", 0, t_a);
        wait_sig("t1_begin", 2, t_b);
        check("t1_setup_lat", 32'(t_b - t_a), 32'(SETUP + 2));
        check("t1_tx_data", 32'(o_spi_tx_data), 32'hE8);
        check("t1_grant", 32'(o_grant), 32'h1);
        wait_idle("t1_idle");
        check("t1_acks", 32'(ack_cnt - a0), 32'd3);
        check("t1_pending", 32'(exp_q[0].size()), 32'd0);

        // Both request right after reset: 0 first, then 1
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        grant_log.delete();
        gap_log.delete();
        o0 = overlap;
        push(0, 8'h11, 1'b1);
        push(1, 8'h22, 1'b1);
        wait_idle("t2_idle");
        check("t2_glog_n", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() == 2) begin
            check("t2_first", 32'(grant_log[0]), 32'h1);
            check("t2_second", 32'(grant_log[1]), 32'h2);
        end
        check("t2_overlap", 32'(overlap - o0), 32'd0);
        gmin = 1 << 30;
        foreach (gap_log[k]) if (gap_log[k] < gmin) gmin = gap_log[k];
        check("t2_gap_ok", 32'(gap_log.size() > 0 && gmin >= GAP), 32'd1);
        check("t2_pending", 32'(exp_q[0].size() + exp_q[1].size()), 32'd0);

        // Requester 0 keeps asking while 1 waits
        grant_log.delete();
        push(0, 8'hA1, 1'b1);
        push(0, 8'hA2, 1'b1);
        push(0, 8'hA3, 1'b1);
        push(1, 8'hB1, 1'b1);
        wait_idle("t3_idle");
        check("t3_glog_n", 32'(grant_log.size()), 32'd4);
        if (grant_log.size() == 4) begin
            check("t3_g0", 32'(grant_log[0]), 32'h1);
            check("t3_g1", 32'(grant_log[1]), 32'h2);
            check("t3_g2", 32'(grant_log[2]), 32'h1);
        end
        check("t3_overlap", 32'(overlap - o0), 32'd0);
        check("t3_pending", 32'(exp_q[0].size() + exp_q[1].size()), 32'd0);

        // Requester drops mid-transaction
        tr0 = terr_cnt;
        push(0, 8'h99, 1'b0);
        wait_sig("t4_ack", 5, t_a);
        wait_sig("t4_terr", 3, t_b);
        check("t4_tmo_lat", 32'(t_b - t_a), 32'(TMO + 1));
        wait_sig("t4_cs_high", 4, t_a);
        check("t4_hold_lat", 32'(t_a - t_b), 32'(HOLD + 1));
        wait_idle("t4_idle");
        check("t4_terr_once", 32'(terr_cnt - tr0), 32'd1);
        check("t4_pending", 32'(exp_q[0].size()), 32'd0);

        // Reset while the engine is busy
        spi_lat = 12;
        tx_q[1].push_back({1'b1, 8'h5A});
        wait_sig("t5_begin", 2, t_a);
        repeat (2) @(negedge clk);
        a0 = ack_cnt;
        rst = 1'b1;
        tx_q[1].delete();
        @(negedge clk);
        check("t5_cs_n", 32'(o_cs_n), 32'h3);
        check("t5_grant", 32'(o_grant), 32'd0);
        check("t5_rx", 32'(o_rx_byte), 32'd0);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check("t5_no_ack", 32'(ack_cnt - a0), 32'd0);
        check("t5_idle_cs", 32'(o_cs_n), 32'h3);
        spi_lat = 3;
        push(1, 8'h3C, 1'b1);
        wait_idle("t5_idle");
        check("t5_new_ack", 32'(ack_cnt - a0), 32'd1);
        check("t5_pending", 32'(exp_q[1].size()), 32'd0);

        // Spurious engine end pulses in IDLE and SETUP
        a0 = ack_cnt;
        inj_end = 1'b1;
        repeat (2) @(negedge clk);
        inj_end = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_idle_grant", 32'(o_grant), 32'd0);
        check("t6_idle_cs", 32'(o_cs_n), 32'h3);
        check("t6_idle_rx", 32'(o_rx_byte), 32'hC3);
        push(0, 8'h42, 1'b1);
        wait_sig("t6_cs0_low", 0, t_a);
        inj_end = 1'b1;
        repeat (2) @(negedge clk);
        inj_end = 1'b0;
        wait_sig("t6_begin", 2, t_b);
        check("t6_setup_lat", 32'(t_b - t_a), 32'(SETUP + 2));
        wait_idle("t6_idle");
        check("t6_acks", 32'(ack_cnt - a0), 32'd1);
        check("t6_pending", 32'(exp_q[0].size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
